// File: rtl/plab5_mcore_mem_reqcmsg_pack_queue.sv
// Packs memory request control fields {type, opaque, addr, len} into one control
// message and buffers it in a 2-entry FIFO with val/rdy handshakes on both sides.
module plab5_mcore_mem_reqcmsg_pack_queue #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_auto_opaque  = 0,
  localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
  localparam int c_msg_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [2:0]                in_type,
  input  logic [p_opaque_nbits-1:0] in_opaque,
  input  logic [p_addr_nbits-1:0]   in_addr,
  input  logic [c_len_nbits-1:0]    in_len,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [c_msg_nbits-1:0]    out_msg,
  output logic [p_opaque_nbits-1:0] tag_next,
  output logic [1:0]                count
);

  function automatic logic [c_msg_nbits-1:0] pack_msg(
    input logic [2:0]                f_type,
    input logic [p_opaque_nbits-1:0] f_opaque,
    input logic [p_addr_nbits-1:0]   f_addr,
    input logic [c_len_nbits-1:0]    f_len
  );
    return {f_type, f_opaque, f_addr, f_len};
  endfunction

  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;
  logic [p_opaque_nbits-1:0] r_tag;
  logic [c_msg_nbits-1:0]    r_entries [2];

  logic                      w_enq;
  logic                      w_deq;
  logic [p_opaque_nbits-1:0] w_opaque;
  logic [c_msg_nbits-1:0]    w_packed;
  logic [1:0]                w_count_next;

  // Ready/valid come purely from registered occupancy; no out_rdy path to in_rdy.
  assign in_rdy  = (r_count != 2'd2);
  assign out_val = (r_count != 2'd0);
  assign w_enq   = in_val && in_rdy;
  assign w_deq   = out_val && out_rdy;

  assign w_opaque = (p_auto_opaque != 0) ? r_tag : in_opaque;
  assign w_packed = pack_msg(in_type, w_opaque, in_addr, in_len);

  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Control state: pointers, occupancy and tag counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_tag    <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_enq) begin
        r_wr_ptr <= ~r_wr_ptr;
        r_tag    <= r_tag + p_opaque_nbits'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Entry storage is left unreset; the output mux zeroes it while empty.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entries[r_wr_ptr] <= w_packed;
    end
  end

  assign out_msg  = out_val ? r_entries[r_rd_ptr] : '0;
  assign tag_next = r_tag;
  assign count    = r_count;

endmodule

// File: tb/tb_plab5_mcore_mem_reqcmsg_pack_queue.sv
// Directed self-checking bench: a pass-through-opaque instance and an auto-opaque instance.
module tb_plab5_mcore_mem_reqcmsg_pack_queue;

  logic        clk;
  logic        reset;

  logic        a_in_val, a_in_rdy, a_out_val, a_out_rdy;
  logic [2:0]  a_in_type;
  logic [7:0]  a_in_opaque, a_tag_next;
  logic [31:0] a_in_addr;
  logic [1:0]  a_in_len, a_count;
  logic [44:0] a_out_msg;

  logic        b_in_val, b_in_rdy, b_out_val, b_out_rdy;
  logic [2:0]  b_in_type;
  logic [7:0]  b_in_opaque, b_tag_next;
  logic [31:0] b_in_addr;
  logic [1:0]  b_in_len, b_count;
  logic [44:0] b_out_msg;

  int n_tests = 0;
  int n_fail  = 0;

  plab5_mcore_mem_reqcmsg_pack_queue #(.p_auto_opaque(0)) u_dut_man (
    .clk(clk), .reset(reset),
    .in_val(a_in_val), .in_rdy(a_in_rdy), .in_type(a_in_type), .in_opaque(a_in_opaque),
    .in_addr(a_in_addr), .in_len(a_in_len),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg),
    .tag_next(a_tag_next), .count(a_count)
  );

  plab5_mcore_mem_reqcmsg_pack_queue #(.p_auto_opaque(1)) u_dut_auto (
    .clk(clk), .reset(reset),
    .in_val(b_in_val), .in_rdy(b_in_rdy), .in_type(b_in_type), .in_opaque(b_in_opaque),
    .in_addr(b_in_addr), .in_len(b_in_len),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg),
    .tag_next(b_tag_next), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a, input logic [1:0] l);
    a_in_type = t; a_in_opaque = o; a_in_addr = a; a_in_len = l;
  endtask

  initial begin
    logic [44:0] exp_msg;
    reset = 1'b0;
    a_in_val = 0; a_out_rdy = 0; drv_a(3'd0, 8'd0, 32'd0, 2'd0);
    b_in_val = 0; b_out_rdy = 0; b_in_type = 0; b_in_opaque = 0; b_in_addr = 0; b_in_len = 0;

    // Reset state
    step(); step();
    chk("rst_count",   {62'd0, a_count},   64'd0);
    chk("rst_out_val", {63'd0, a_out_val}, 64'd0);
    chk("rst_out_msg", {19'd0, a_out_msg}, 64'd0);
    chk("rst_tag",     {56'd0, a_tag_next}, 64'd0);
    reset = 1'b1;
    step();
    chk("rst_in_rdy",  {63'd0, a_in_rdy},  64'd1);

    // Single write
    drv_a(3'd1, 8'h5A, 32'h0000_1004, 2'd0);
    a_in_val = 1; a_out_rdy = 1;
    step();
    a_in_val = 0;
    chk("single_val",   {63'd0, a_out_val}, 64'd1);
    chk("single_msg",   {19'd0, a_out_msg}, 64'h568_0000_4010);
    chk("single_count", {62'd0, a_count},   64'd1);
    step();
    chk("single_drain", {62'd0, a_count},   64'd0);
    chk("single_tag",   {56'd0, a_tag_next}, 64'd1);

    // Backpressure: A, B accepted, C held off until a slot frees
    a_out_rdy = 0;
    drv_a(3'd0, 8'h11, 32'h0000_0100, 2'd1); a_in_val = 1;
    step();
    drv_a(3'd1, 8'h22, 32'h0000_0200, 2'd2);
    step();
    drv_a(3'd2, 8'h33, 32'h0000_0300, 2'd3);
    chk("bp_count2", {62'd0, a_count},   64'd2);
    chk("bp_in_rdy", {63'd0, a_in_rdy},  64'd0);
    chk("bp_head_a", {19'd0, a_out_msg}, 64'h044_0000_0401);
    step();
    chk("bp_hold_cnt",  {62'd0, a_count},   64'd2);
    chk("bp_hold_head", {19'd0, a_out_msg}, 64'h044_0000_0401);
    a_out_rdy = 1;
    step();
    chk("bp_deq_a_cnt", {62'd0, a_count},   64'd1);
    chk("bp_head_b",    {19'd0, a_out_msg}, 64'h488_0000_0802);
    step();
    a_in_val = 0;
    chk("bp_c_cnt",  {62'd0, a_count},   64'd1);
    chk("bp_head_c", {19'd0, a_out_msg}, 64'h8CC_0000_0C03);
    step();
    chk("bp_empty", {62'd0, a_count}, 64'd0);

    // Streaming at count=1: one in, one out each cycle
    drv_a(3'd1, 8'h40, 32'hA000_0000, 2'd0); a_in_val = 1; a_out_rdy = 1;
    step();
    chk("stream_start", {62'd0, a_count}, 64'd1);
    for (int i = 1; i <= 10; i++) begin
      drv_a(3'd1, 8'(8'h40 + i), 32'hA000_0000 + 32'(i), 2'(i));
      step();
      exp_msg = {3'd1, 8'(8'h40 + i), 32'hA000_0000 + 32'(i), 2'(i)};
      chk("stream_cnt", {62'd0, a_count},   64'd1);
      chk("stream_val", {63'd0, a_out_val}, 64'd1);
      chk("stream_msg", {19'd0, a_out_msg}, {19'd0, exp_msg});
    end
    a_in_val = 0;
    step();
    chk("stream_end", {62'd0, a_count}, 64'd0);

    // Auto opaque: 258 requests, in_opaque ignored, tag wraps
    b_in_type = 3'd1; b_in_opaque = 8'hFF; b_in_len = 2'd0; b_out_rdy = 1; b_in_val = 1;
    for (int i = 0; i < 258; i++) begin
      b_in_addr = 32'(i);
      step();
      chk("auto_opaque", {56'd0, b_out_msg[41:34]}, {56'd0, 8'(i)});
      chk("auto_addr",   {32'd0, b_out_msg[33:2]},  {32'd0, 32'(i)});
    end
    b_in_val = 0;
    step();
    chk("auto_tag_end", {56'd0, b_tag_next}, 64'h02);
    chk("auto_empty",   {62'd0, b_count},    64'd0);

    // Async reset mid-cycle with a full FIFO
    a_out_rdy = 0; a_in_val = 1;
    drv_a(3'd1, 8'h77, 32'h1234_5678, 2'd1);
    step(); step();
    a_in_val = 0;
    chk("arst_pre_cnt", {62'd0, a_count}, 64'd2);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_out_val", {63'd0, a_out_val},  64'd0);
    chk("arst_count",   {62'd0, a_count},    64'd0);
    chk("arst_tag_a",   {56'd0, a_tag_next}, 64'd0);
    chk("arst_tag_b",   {56'd0, b_tag_next}, 64'd0);
    step();
    #4;
    reset = 1'b1;
    step();

    // Field boundaries
    drv_a(3'd7, 8'h00, 32'hFFFF_FFFF, 2'd3); a_in_val = 1; a_out_rdy = 1;
    step();
    chk("bound_ones", {19'd0, a_out_msg}, 64'h1C03_FFFF_FFFF);
    drv_a(3'd0, 8'hFF, 32'h0000_0000, 2'd0);
    step();
    chk("bound_opq",  {19'd0, a_out_msg}, 64'h3FC_0000_0000);
    a_in_val = 0;
    step();
    chk("bound_tag",  {56'd0, a_tag_next}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
